// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one shared full adder, LSB-first, carry held in a flip-flop.
// Optional subtract mode is enabled by defining SERIAL_SUBTRACT_EN (adds port din_sub).

module full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_sum,
    output logic o_cout
);
    assign o_sum  = i_a ^ i_b ^ i_cin;
    assign o_cout = (i_a & i_b) | (i_a & i_cin) | (i_b & i_cin);
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din_start,
    input  logic [WIDTH-1:0] din_A,
    input  logic [WIDTH-1:0] din_B,
    input  logic             din_cin,
`ifdef SERIAL_SUBTRACT_EN
    input  logic             din_sub,
`endif
    output logic             dout_busy,
    output logic             dout_done,
    output logic [WIDTH-1:0] dout_sum,
    output logic             dout_carry
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    // Only WIDTH-1 partial bits are stored; the final bit comes straight from the adder.
    logic [WIDTH-2:0] r_sum_sr;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;

    logic             w_fa_sum;
    logic             w_fa_cout;
    logic [WIDTH-1:0] w_sum_next;
    logic [WIDTH-1:0] w_b_load;
    logic             w_cin_load;

`ifdef SERIAL_SUBTRACT_EN
    // Subtraction as A + ~B + 1; carry-out of 1 then means no borrow.
    assign w_b_load   = din_sub ? ~din_B : din_B;
    assign w_cin_load = din_sub ? 1'b1   : din_cin;
`else
    assign w_b_load   = din_B;
    assign w_cin_load = din_cin;
`endif

    full_adder u_fa (
        .i_a    (r_a_sr[0]),
        .i_b    (r_b_sr[0]),
        .i_cin  (r_carry),
        .o_sum  (w_fa_sum),
        .o_cout (w_fa_cout)
    );

    assign w_sum_next = {w_fa_sum, r_sum_sr};

    // NOTE: every register here is state, so all use <= and all are cleared by the async reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_a_sr   <= '0;
            r_b_sr   <= '0;
            r_sum_sr <= '0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_sum    <= '0;
            r_cout   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (din_start) begin
                        r_a_sr  <= din_A;
                        r_b_sr  <= w_b_load;
                        r_carry <= w_cin_load;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_a_sr   <= r_a_sr >> 1;
                    r_b_sr   <= r_b_sr >> 1;
                    r_sum_sr <= w_sum_next[WIDTH-1:1];
                    r_carry  <= w_fa_cout;
                    if (r_cnt == LAST_BIT) begin
                        // Counter is left at WIDTH-1 so it never wraps within an operation.
                        r_sum   <= w_sum_next;
                        r_cout  <= w_fa_cout;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign dout_busy  = r_busy;
    assign dout_done  = r_done;
    assign dout_sum   = r_sum;
    assign dout_carry = r_cout;

endmodule
